elastic_fifo: RTL and testbench

ELASTIC_FIFO -- requirements
Module: elastic_fifo

---
 rtl/elastic_fifo_if.sv | 29 ++
 rtl/elastic_fifo.sv | 103 ++++++++++
 tb/tb_elastic_fifo.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/elastic_fifo_if.sv
// elastic_fifo_if: valid/stop handshake bundle around an elastic FIFO.
//   Upstream side : data_input, valid_input  -> FIFO ; stop_input  <- FIFO
//   Downstream    : data_output, valid_output <- FIFO ; stop_output -> FIFO
//   Status        : occupancy <- FIFO (number of stored entries)
// master modport = environment driving the FIFO, slave modport = the FIFO itself.
interface elastic_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] data_input;
  logic                  valid_input;
  logic                  stop_input;
  logic [DATA_WIDTH-1:0] data_output;
  logic                  valid_output;
  logic                  stop_output;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    output data_input, valid_input, stop_output,
    input  stop_input, data_output, valid_output, occupancy
  );

  modport slave (
    input  data_input, valid_input, stop_output,
    output stop_input, data_output, valid_output, occupancy
  );
endinterface

// File: rtl/elastic_fifo.sv
// elastic_fifo: DEPTH-entry circular-buffer FIFO with valid/stop handshakes.
//   clk     : single clock, all state updates on the rising edge
//   reset_n : asynchronous active-low reset (pointers/occupancy clear at once)
//   bus     : elastic_fifo_if.slave (data/valid/stop in, data/valid/stop out,
//             occupancy)
// DEPTH legal range 2..16; need not be a power of two.
// Optional macro ELASTIC_FIFO_BYPASS_EN: when empty, the input is presented
// on the output in the same cycle and passes through without a write if
// downstream is not stopped. stop_input always depends on occupancy only.
module elastic_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  elastic_fifo_if.slave  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [OCC_W-1:0]      occ_q;
  logic                  full_q;
  logic                  nonempty_q;

  logic                  push_c;
  logic                  pop_c;
  logic                  bypass_c;
  logic [OCC_W-1:0]      occ_d_c;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return PTR_W'(p + 1'b1);
  endfunction

  // Pass-through transfer: empty, upstream valid, downstream ready.
`ifdef ELASTIC_FIFO_BYPASS_EN
  assign bypass_c = ~nonempty_q & bus.valid_input & ~bus.stop_output;
`else
  assign bypass_c = 1'b0;
`endif

  // Push blocked by the registered full flag, so a pop while full never
  // frees a slot for the same cycle.
  assign push_c = bus.valid_input & ~full_q & ~bypass_c;
  assign pop_c  = nonempty_q & ~bus.stop_output;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    occ_d_c = occ_q;
    unique case ({push_c, pop_c})
      2'b10:   occ_d_c = occ_q + OCC_W'(1);
      2'b01:   occ_d_c = occ_q - OCC_W'(1);
      default: occ_d_c = occ_q;
    endcase
  end

  // Control state: pointers, occupancy and decoded status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      full_q     <= 1'b0;
      nonempty_q <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop_c) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      occ_q      <= occ_d_c;
      full_q     <= (occ_d_c == OCC_W'(DEPTH));
      nonempty_q <= (occ_d_c != '0);
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= bus.data_input;
    end
  end

  assign bus.stop_input = full_q;
  assign bus.occupancy  = occ_q;

`ifdef ELASTIC_FIFO_BYPASS_EN
  assign bus.valid_output = nonempty_q | bus.valid_input;
  assign bus.data_output  = nonempty_q ? mem[rd_ptr_q] : bus.data_input;
`else
  assign bus.valid_output = nonempty_q;
  assign bus.data_output  = mem[rd_ptr_q];
`endif

endmodule

// File: tb/tb_elastic_fifo.sv
// tb_elastic_fifo: directed bench for elastic_fifo at DEPTH=2 and DEPTH=3.
// A reference queue per instance holds accepted data; each step checks
// valid/stop/occupancy/data against it, then updates it.
module tb_elastic_fifo;

`ifdef ELASTIC_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic [7:0] q2[$];
  logic [7:0] q3[$];

  elastic_fifo_if #(.DATA_WIDTH(8), .DEPTH(2)) b2();
  elastic_fifo_if #(.DATA_WIDTH(8), .DEPTH(3)) b3();

  elastic_fifo #(.DATA_WIDTH(8), .DEPTH(2)) u2 (.clk(clk), .reset_n(reset_n), .bus(b2));
  elastic_fifo #(.DATA_WIDTH(8), .DEPTH(3)) u3 (.clk(clk), .reset_n(reset_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on instance sel (2 or 3); the other instance is frozen.
  task automatic step(input int sel, input logic vin, input logic [7:0] din,
                      input logic sout, output logic acc);
    int d;
    int occ;
    logic [7:0] head;
    logic ov, os;
    logic [7:0] od;
    logic [1:0] oo;
    logic ev;
    logic [7:0] ed;
    logic push, pop;
    head = 8'h00;
    if (sel == 2) begin
      b2.valid_input = vin; b2.data_input = din; b2.stop_output = sout;
      b3.valid_input = 1'b0; b3.stop_output = 1'b1;
      d = 2; occ = q2.size();
      if (occ != 0) head = q2[0];
    end else begin
      b3.valid_input = vin; b3.data_input = din; b3.stop_output = sout;
      b2.valid_input = 1'b0; b2.stop_output = 1'b1;
      d = 3; occ = q3.size();
      if (occ != 0) head = q3[0];
    end
    @(negedge clk);
    if (sel == 2) begin
      ov = b2.valid_output; os = b2.stop_input; od = b2.data_output; oo = b2.occupancy;
    end else begin
      ov = b3.valid_output; os = b3.stop_input; od = b3.data_output; oo = b3.occupancy;
    end
    ev = (occ != 0) || (BYP && vin);
    ed = (occ != 0) ? head : din;
    chk("valid_output", 32'(ov), 32'(ev));
    chk("stop_input", 32'(os), 32'(occ == d));
    chk("occupancy", 32'(oo), 32'(occ));
    if (ev) chk("data_output", 32'(od), 32'(ed));
    if (occ != 0) begin
      pop  = !sout;
      push = vin && (occ != d);
    end else begin
      pop  = 1'b0;
      push = vin && !(BYP && !sout);
    end
    acc = push || (occ == 0 && BYP && vin && !sout);
    if (sel == 2) begin
      if (pop) void'(q2.pop_front());
      if (push) q2.push_back(din);
    end else begin
      if (pop) void'(q3.pop_front());
      if (push) q3.push_back(din);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    int   idx;
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    b2.valid_input = 1'b0; b2.data_input = 8'h00; b2.stop_output = 1'b1;
    b3.valid_input = 1'b0; b3.data_input = 8'h00; b3.stop_output = 1'b1;

    // Reset state.
    #2;
    chk("rst_valid2", 32'(b2.valid_output), 32'd0);
    chk("rst_stop2", 32'(b2.stop_input), 32'd0);
    chk("rst_occ2", 32'(b2.occupancy), 32'd0);
    chk("rst_valid3", 32'(b3.valid_output), 32'd0);
    chk("rst_occ3", 32'(b3.occupancy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming with no backpressure: one-cycle latency, occupancy <= 1.
    step(2, 1'b1, 8'hA1, 1'b0, acc);
    step(2, 1'b1, 8'hA2, 1'b0, acc);
    step(2, 1'b1, 8'hA3, 1'b0, acc);
    step(2, 1'b0, 8'h00, 1'b0, acc);
    step(2, 1'b0, 8'h00, 1'b0, acc);

    // Downstream stopped: fill, hold third word upstream, then release.
    step(2, 1'b1, 8'h11, 1'b1, acc);
    step(2, 1'b1, 8'h22, 1'b1, acc);
    step(2, 1'b1, 8'h33, 1'b1, acc);
    chk("held_33", 32'(acc), 32'd0);
    step(2, 1'b1, 8'h33, 1'b0, acc);
    step(2, 1'b1, 8'h33, 1'b0, acc);
    chk("accept_33", 32'(acc), 32'd1);
    step(2, 1'b0, 8'h00, 1'b0, acc);
    step(2, 1'b0, 8'h00, 1'b0, acc);

    // Full with pop and valid input in the same cycle: no push.
    step(2, 1'b1, 8'hC1, 1'b1, acc);
    step(2, 1'b1, 8'hC2, 1'b1, acc);
    step(2, 1'b1, 8'hC3, 1'b0, acc);
    chk("full_pop_no_push", 32'(acc), 32'd0);
    step(2, 1'b0, 8'h00, 1'b1, acc);
    step(2, 1'b0, 8'h00, 1'b0, acc);
    step(2, 1'b0, 8'h00, 1'b0, acc);

    // DEPTH=3 with random downstream stop: pointer wrap and ordering.
    idx = 0;
    for (int k = 0; k < 60 && idx < 10; k++) begin
      step(3, 1'b1, 8'(8'h30 + idx), 1'($urandom_range(0, 1)), acc);
      if (acc) idx++;
    end
    chk("push_budget3", 32'(idx), 32'd10);
    for (int k = 0; k < 20 && q3.size() != 0; k++) begin
      step(3, 1'b0, 8'h00, 1'b0, acc);
    end
    chk("drain_budget3", 32'(q3.size()), 32'd0);
    step(3, 1'b0, 8'h00, 1'b0, acc);

    // Asynchronous reset between edges while holding two entries.
    step(2, 1'b1, 8'h51, 1'b1, acc);
    step(2, 1'b1, 8'h52, 1'b1, acc);
    b2.valid_input = 1'b0;
    b2.stop_output = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(b2.valid_output), 32'd0);
    chk("async_rst_occ", 32'(b2.occupancy), 32'd0);
    chk("async_rst_stop", 32'(b2.stop_input), 32'd0);
    q2.delete();
    q3.delete();
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(2, 1'b1, 8'h5A, 1'b0, acc);
    step(2, 1'b0, 8'h00, 1'b0, acc);
    step(2, 1'b0, 8'h00, 1'b0, acc);

    // Empty, downstream ready, single word (zero-latency when bypass built).
    step(2, 1'b1, 8'h77, 1'b0, acc);
    step(2, 1'b0, 8'h00, 1'b0, acc);
    step(2, 1'b0, 8'h00, 1'b0, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
